// File: rtl/reflet_irq_ctrl_pkg.sv
// Shared constants and types for the reflet interrupt controller:
// register offsets, pulser state encoding and line count.
package reflet_irq_ctrl_pkg;

   localparam int NUM_IRQ = 4;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_SOFT    = 2'd2;
   localparam logic [1:0] REG_ACTIVE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      DONE  = 2'd2
   } pulser_state_t;

   // Counter wide enough to hold pulse_len-1 with one spare bit.
   function automatic int cnt_width(input int len);
      return $clog2(len) + 1;
   endfunction

endpackage

// File: rtl/reflet_irq_pulser.sv
// Per-line request pulser: one fixed-length pulse per assertion episode
// of 'active'; a started pulse always runs to completion.
module reflet_irq_pulser
   import reflet_irq_ctrl_pkg::*;
#(
   parameter int pulse_len = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic active,
   output logic request
);

   localparam int CW = cnt_width(pulse_len);
   localparam logic [CW-1:0] CNT_LOAD = CW'(pulse_len - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   pulser_state_t   state_r;
   pulser_state_t   state_next_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_next_s;
   logic            request_r;

   // State, counter and registered request output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         request_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         cnt_r     <= cnt_next_s;
         request_r <= (state_r == PULSE);
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (active && enable) begin
               state_next_s = PULSE;
               cnt_next_s   = CNT_LOAD;
            end else begin
               state_next_s = IDLE;
            end
         end
         PULSE: begin
            if (cnt_r == CNT_ZERO) begin
               state_next_s = DONE;
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         DONE: begin
            // Stay here until the episode ends, so each episode pulses once.
            if (!active) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = CNT_ZERO;
         end
      endcase
   end

   assign request = request_r;

endmodule

// File: rtl/reflet_irq_ctrl.sv
// Memory-mapped interrupt controller for reflet_cpu: edge capture, pending/mask
// registers with W1C and soft-set, and one request pulser per line.
module reflet_irq_ctrl
   import reflet_irq_ctrl_pkg::*;
#(
   parameter int                  wordsize  = 16,
   parameter logic [wordsize-1:0] base_addr = 16'hFF00,
   parameter int                  pulse_len = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [wordsize-1:0] addr,
   input  logic [wordsize-1:0] data_in,
   input  logic                write_en,
   output logic [wordsize-1:0] data_out,
   input  logic [NUM_IRQ-1:0]  irq_src,
   output logic [NUM_IRQ-1:0]  interrupt_request
);

   logic [NUM_IRQ-1:0]  prev_r;
   logic [NUM_IRQ-1:0]  pending_r;
   logic [NUM_IRQ-1:0]  mask_r;
   logic [wordsize-1:0] data_out_r;

   logic                hit_s;
   logic                wr_s;
   logic [1:0]          offset_s;
   logic [NUM_IRQ-1:0]  rise_s;
   logic [NUM_IRQ-1:0]  clr_s;
   logic [NUM_IRQ-1:0]  soft_s;
   logic [NUM_IRQ-1:0]  mask_next_s;
   logic [NUM_IRQ-1:0]  pending_next_s;
   logic [NUM_IRQ-1:0]  rd_s;
   logic [NUM_IRQ-1:0]  active_s;
   logic [NUM_IRQ-1:0]  request_s;
   logic                unused_data_s;

   // Address decode, register write effects and read mux.
   always_comb begin
      hit_s       = (addr[wordsize-1:2] == base_addr[wordsize-1:2]);
      offset_s    = addr[1:0];
      wr_s        = write_en & enable & hit_s;
      rise_s      = irq_src & ~prev_r;
      clr_s       = 4'b0000;
      soft_s      = 4'b0000;
      mask_next_s = mask_r;
      rd_s        = 4'b0000;
      case (offset_s)
         REG_PENDING: begin
            rd_s = pending_r;
            if (wr_s) begin
               clr_s = data_in[NUM_IRQ-1:0];
            end else begin
               clr_s = 4'b0000;
            end
         end
         REG_MASK: begin
            rd_s = mask_r;
            if (wr_s) begin
               mask_next_s = data_in[NUM_IRQ-1:0];
            end else begin
               mask_next_s = mask_r;
            end
         end
         REG_SOFT: begin
            if (wr_s) begin
               soft_s = data_in[NUM_IRQ-1:0];
            end else begin
               soft_s = 4'b0000;
            end
         end
         REG_ACTIVE: begin
            rd_s = pending_r & mask_r;
         end
         default: begin
            rd_s = 4'b0000;
         end
      endcase
      // Setting terms are OR-ed last so a same-cycle set beats a clear.
      pending_next_s = (pending_r & ~clr_s) | rise_s | soft_s;
   end

   assign active_s      = pending_r & mask_r;
   assign unused_data_s = ^data_in[wordsize-1:NUM_IRQ];

   // History starts all-ones so lines held high through reset do not fire.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_r     <= 4'b1111;
         pending_r  <= 4'b0000;
         mask_r     <= 4'b0000;
         data_out_r <= {wordsize{1'b0}};
      end else begin
         prev_r     <= irq_src;
         pending_r  <= pending_next_s;
         mask_r     <= mask_next_s;
         data_out_r <= hit_s ? {{(wordsize-NUM_IRQ){1'b0}}, rd_s} : {wordsize{1'b0}};
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_IRQ; g++) begin : g_pulser
         reflet_irq_pulser #(
            .pulse_len (pulse_len)
         ) u_pulser (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .active  (active_s[g]),
            .request (request_s[g])
         );
      end
   endgenerate

   assign data_out          = data_out_r;
   assign interrupt_request = request_s;

endmodule

// File: tb/tb_reflet_irq_ctrl.sv
// Table-driven bench for reflet_irq_ctrl (wordsize 16, base FF00, pulse_len 5)
// with hand-written multi-cycle sequences at the end.
module tb_reflet_irq_ctrl;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] addr;
      logic [15:0] din;
      logic        we;
      logic [3:0]  src;
      logic [15:0] exp_do;
      logic [3:0]  exp_irq;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        write_en;
   logic [15:0] data_out;
   logic [3:0]  irq_src;
   logic [3:0]  interrupt_request;

   int   n_vec  = 0;
   int   n_miss = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   reflet_irq_ctrl #(
      .wordsize  (16),
      .base_addr (16'hFF00),
      .pulse_len (5)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .addr              (addr),
      .data_in           (data_in),
      .write_en          (write_en),
      .data_out          (data_out),
      .irq_src           (irq_src),
      .interrupt_request (interrupt_request)
   );

   task automatic add(input int n, input logic r, input logic e, input logic [15:0] a,
                      input logic [15:0] d, input logic w, input logic [3:0] s,
                      input logic [15:0] edo, input logic [3:0] eirq);
      vec_t v;
      v.rst = r; v.en = e; v.addr = a; v.din = d; v.we = w; v.src = s;
      v.exp_do = edo; v.exp_irq = eirq;
      repeat (n) vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic apply(input logic r, input logic e, input logic [15:0] a,
                        input logic [15:0] d, input logic w, input logic [3:0] s);
      reset = r; enable = e; addr = a; data_in = d; write_en = w; irq_src = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] edo, input logic [3:0] eirq);
      n_vec++;
      if (data_out !== edo || interrupt_request !== eirq) begin
         n_miss++;
         $display("FAIL %s: got data_out=%h irq=%b, expected data_out=%h irq=%b",
                  name, data_out, interrupt_request, edo, eirq);
      end
   endtask

   initial begin
      // 1: reset, then read all four registers
      add(3, 1, 1, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF01, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF02, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF03, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      // 2: mask line 0, edge at k, pulse after k+2..k+6
      add(1, 0, 1, 16'hFF01, 16'h0001, 1, 4'h0, 16'h0000, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0000, 0, 4'h1, 16'h0001, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h1);
      add(1, 0, 1, 16'hFF03, 16'h0000, 0, 4'h1, 16'h0001, 4'h1);
      add(3, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h1);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      // 3: second edge without clear gives nothing; clear then edge re-arms
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      add(3, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0001, 1, 4'h1, 16'h0001, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      add(2, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(5, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h1);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0001, 1, 4'h1, 16'h0001, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      // 4: enable low defers the pulse and blocks register writes
      add(1, 0, 1, 16'hFF01, 16'h0002, 1, 4'h0, 16'h0001, 4'h0);
      add(2, 0, 0, 16'h0000, 16'h0000, 0, 4'h2, 16'h0000, 4'h0);
      add(1, 0, 0, 16'hFF01, 16'h000F, 1, 4'h2, 16'h0002, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h2, 16'h0000, 4'h0);
      add(5, 0, 1, 16'h0000, 16'h0000, 0, 4'h2, 16'h0000, 4'h2);
      add(1, 0, 1, 16'hFF01, 16'h0000, 0, 4'h2, 16'h0002, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h000F, 1, 4'h2, 16'h0002, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      // 5: set beats clear; soft set pulses line 3
      add(1, 0, 1, 16'hFF00, 16'h0004, 1, 4'h4, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0000, 0, 4'h4, 16'h0004, 4'h0);
      add(1, 0, 1, 16'hFF01, 16'h0008, 1, 4'h4, 16'h0002, 4'h0);
      add(1, 0, 1, 16'hFF02, 16'h0008, 1, 4'h4, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0000, 0, 4'h4, 16'h000C, 4'h0);
      add(5, 0, 1, 16'h0000, 16'h0000, 0, 4'h4, 16'h0000, 4'h8);
      add(1, 0, 1, 16'hFF03, 16'h0000, 0, 4'h4, 16'h0008, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h000F, 1, 4'h0, 16'h000C, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 4'h0);
      // 6: masked source waits for unmask; undecoded address reads 0
      add(1, 0, 1, 16'hFF01, 16'h0000, 1, 4'h0, 16'h0008, 4'h0);
      add(1, 0, 1, 16'h0000, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF03, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(1, 0, 1, 16'hFF00, 16'h0000, 0, 4'h1, 16'h0001, 4'h0);
      add(1, 0, 1, 16'hFF01, 16'h0001, 1, 4'h1, 16'h0000, 4'h0);
      add(1, 0, 1, 16'h0040, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);
      add(5, 0, 1, 16'h0040, 16'h0000, 0, 4'h1, 16'h0000, 4'h1);
      add(1, 0, 1, 16'h0040, 16'h0000, 0, 4'h1, 16'h0000, 4'h0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].en, vecs[i].addr, vecs[i].din, vecs[i].we, vecs[i].src);
         chk($sformatf("vec%0d", i), vecs[i].exp_do, vecs[i].exp_irq);
      end

      // Clearing during a pulse does not cut it short; DONE lasts one cycle.
      apply(0, 1, 16'hFF00, 16'h0001, 1, 4'h1); chk("clr_done", 16'h0001, 4'h0);
      apply(0, 1, 16'hFF02, 16'h0001, 1, 4'h1); chk("soft_set", 16'h0000, 4'h0);
      apply(0, 1, 16'h0000, 16'h0000, 0, 4'h1); chk("soft_start", 16'h0000, 4'h0);
      apply(0, 1, 16'hFF00, 16'h0001, 1, 4'h1); chk("clr_in_pulse", 16'h0001, 4'h1);
      for (int i = 0; i < 4; i++) begin
         apply(0, 1, 16'h0000, 16'h0000, 0, 4'h1); chk("pulse_runs", 16'h0000, 4'h1);
      end
      apply(0, 1, 16'h0000, 16'h0000, 0, 4'h1); chk("pulse_end", 16'h0000, 4'h0);
      apply(0, 1, 16'hFF02, 16'h0001, 1, 4'h1); chk("rearm_soft", 16'h0000, 4'h0);
      apply(0, 1, 16'h0000, 16'h0000, 0, 4'h1); chk("rearm_start", 16'h0000, 4'h0);
      apply(0, 1, 16'h0000, 16'h0000, 0, 4'h1); chk("rearm_pulse", 16'h0000, 4'h1);

      // Reset mid-pulse drops the request; a line held high through reset stays quiet.
      apply(1, 1, 16'h0000, 16'h0000, 0, 4'h1); chk("reset_mid_pulse", 16'h0000, 4'h0);
      apply(1, 1, 16'h0000, 16'h0000, 0, 4'h1); chk("reset_hold", 16'h0000, 4'h0);
      apply(0, 1, 16'hFF00, 16'h0000, 0, 4'h1); chk("pend_post_reset0", 16'h0000, 4'h0);
      apply(0, 1, 16'hFF00, 16'h0000, 0, 4'h1); chk("pend_post_reset1", 16'h0000, 4'h0);
      apply(0, 1, 16'hFF01, 16'hFFF2, 1, 4'h1); chk("mask_wide_write", 16'h0000, 4'h0);
      apply(0, 1, 16'hFF01, 16'h0000, 0, 4'h1); chk("mask_upper_ignored", 16'h0002, 4'h0);
      apply(0, 1, 16'hFF00, 16'h0000, 0, 4'h1); chk("pend_still_zero", 16'h0000, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/reflet_irq_ctrl.md
Name: reflet_irq_ctrl

Overview:
- Memory-mapped interrupt controller that acts as a bus responder to reflet_cpu and drives the CPU's 4-bit interrupt_request input.
- Captures rising edges on 4 peripheral event lines and latches them as pending. Pending bits are masked, then turned into fixed-length request pulses, one per assertion episode.
- Software acknowledges by write-1-to-clear. Sits on the CPU data bus beside ROM/RAM; its data_out is OR-ed into the CPU data_in mux.

Parameters:
- wordsize, 16, bus data/address width; must be >= 4.
- base_addr, 16'hFF00, first of 4 consecutive register addresses; must be 4-aligned.
- pulse_len, 5, request pulse length in clk cycles; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  CPU enable; gates register writes and pulse starts.
- addr  in  wordsize  CPU address.
- data_in  in  wordsize  CPU write data (CPU data_out).
- write_en  in  1  CPU write strobe.
- data_out  out  wordsize  read data; 0 when addr is not decoded.
- irq_src  in  4  peripheral event lines, rising-edge sensitive.
- interrupt_request  out  4  to CPU interrupt_request.

Behaviour:
- One clk. Reset is synchronous and active-high.
- Reset values:
  - pending, mask, data_out, interrupt_request = 0.
  - irq_src history register = 4'b1111, so a source held high through reset does not fire.
  - All pulsers in IDLE.
- Address decode: hit = addr[wordsize-1:2] == base_addr[wordsize-1:2]. Register offset = addr[1:0].
- Register map (bits above [3:0] read 0; writes to them are ignored):
  - off 0 PENDING: read pending. Write: pending &= ~data_in[3:0] (W1C).
  - off 1 MASK: read/write. Reset 0.
  - off 2 SOFT: write sets pending |= data_in[3:0]. Reads 0.
  - off 3 ACTIVE: read-only, returns pending & mask. Writes ignored.
- Writes take effect at the clk edge when write_en & enable & hit.
- Reads: data_out registered. It presents the value of addr sampled at edge k after edge k, which is 1-cycle latency, the same timing as ROM. If there is no hit, data_out = 0. Reads are not gated by enable.
- Edge capture: rise = irq_src & ~prev, and prev <= irq_src every cycle. Capture runs regardless of enable.
- Pending update:
  - pending_next = (pending & ~clr) | rise | soft.
  - When set and clear hit the same bit in the same cycle, set wins.
- Per-line pulser FSM, one instance per bit; active = pending & mask for that bit:
  - IDLE: if active & enable, go to PULSE and load cnt = pulse_len-1.
  - PULSE: request = 1. If cnt == 0, go to DONE; else cnt--. A pulse in progress always runs to completion, even if enable or active drops.
  - DONE: request = 0. If !active, go to IDLE. This gives one pulse per assertion episode; re-arming needs a clear or unmask-off.
  - Exiting PULSE when active is already 0 passes through DONE for 1 cycle, then goes to IDLE.
- interrupt_request[i] is the registered PULSE state. Latency from the irq_src edge sampled at edge k to the request rising: the request goes high after edge k+2.
- enable low defers pulse start. The pulse begins 1 cycle after enable returns high, provided active is still set.
- Counter width is clog2(pulse_len)+1. When pulse_len = 1, the FSM goes PULSE to DONE after a single cycle.
- Reset asserted mid-pulse drops the request on the next edge.

Decomposition:
- Shared package/header holds:
  - register offset constants: REG_PENDING=0, REG_MASK=1, REG_SOFT=2, REG_ACTIVE=3.
  - pulser state encoding: IDLE=0, PULSE=1, DONE=2.
  - NUM_IRQ=4.
- One natural sub-module, reflet_irq_pulser. It holds the per-line FSM and counter, with ports clk, reset, enable, active, request, and parameter pulse_len. It is instantiated 4 times in a generate loop.

Test Plan:
All scenarios use wordsize=16, base_addr=16'hFF00, pulse_len=5.
1. Reset held 3 cycles, then read FF00..FF03 -> data_out = 0x0000 for each, interrupt_request = 0.
2. Write MASK=0x0001, then irq_src[0] rises at edge k -> PENDING reads 0x0001. interrupt_request[0] is high after edges k+2..k+6 (5 cycles), then 0.
3. After scenario 2, a second edge on irq_src[0] -> no new pulse. Write PENDING=0x0001 (cleared), then a new edge -> a fresh 5-cycle pulse.
4. MASK=0x0002, enable=0, irq_src[1] edge -> no request while enable is low. enable=1 -> interrupt_request[1] rises 1 cycle later, high for 5 cycles.
5. Write PENDING=0x0004 in the same cycle as an irq_src[2] edge -> PENDING bit 2 reads 1. SOFT write 0x0008 with MASK=0x0008 -> pulse on interrupt_request[3].
6. Masked source: MASK=0, edge on irq_src[0] -> ACTIVE=0, no pulse. Write MASK=0x0001 -> pulse begins. Read at addr 0x0040 -> data_out = 0.
